// File: rtl/spi_eeprom_sequencer.sv
// Expands one EEPROM read/write command into the 25xx SPI byte sequence for the byte-level sender.
// Optional feature macro: SPI_SEQ_WIP_POLL_EN (RDSR polling of WIP after each write frame).
module spi_eeprom_sequencer #(
    parameter int          GAP_CYCLES = 4,
    parameter logic [15:0] POLL_MAX   = 16'hFFFF
) (
    input  logic        bus2ip_clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        txf_rd,
    input  logic [7:0]  txf_dout,
    input  logic        txf_empty,
    output logic        rxf_wr,
    output logic [7:0]  rxf_din,
    input  logic        rxf_full,
    output logic        spi_start,
    output logic        spi_continued,
    output logic [7:0]  spi_txData,
    input  logic [7:0]  spi_rxData,
    input  logic        spi_ready
);

`ifdef SPI_SEQ_WIP_POLL_EN
    typedef enum logic [3:0] {
        S_IDLE, S_WREN, S_GAP, S_HDR, S_FETCH, S_LOAD, S_SEND, S_WAIT, S_PUSH, S_POLL, S_DONE
    } state_t;
    typedef enum logic [2:0] {PH_WREN, PH_HDR, PH_DATA, PH_RDSR_CMD, PH_RDSR_STAT} phase_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_WREN, S_GAP, S_HDR, S_FETCH, S_LOAD, S_SEND, S_WAIT, S_PUSH, S_DONE
    } state_t;
    typedef enum logic [2:0] {PH_WREN, PH_HDR, PH_DATA} phase_t;
`endif

    // Two cycles of the gap are spent in WAIT->GAP entry and in the issuing state itself.
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 2);

    state_t      state_r, state_s;
    phase_t      phase_r, phase_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [1:0]  idx_r, idx_s;
    logic [7:0]  gap_r, gap_s;
    logic        dir_r, dir_s;
    logic [15:0] addr_r, addr_s;
    logic        ready_q_r;
    logic        ready_rise_s;
    logic        cmd_ready_s, busy_s, done_s, err_s;
    logic        txf_rd_s, rxf_wr_s, spi_start_s, spi_continued_s;
    logic [7:0]  rxf_din_s, spi_txData_s;
`ifdef SPI_SEQ_WIP_POLL_EN
    logic [15:0] poll_r, poll_s;
`endif

    assign ready_rise_s = spi_ready & ~ready_q_r;

    // State register and registered outputs.
    always_ff @(posedge bus2ip_clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            phase_r       <= PH_WREN;
            cnt_r         <= 4'd0;
            idx_r         <= 2'd0;
            gap_r         <= 8'd0;
            dir_r         <= 1'b0;
            addr_r        <= 16'd0;
            ready_q_r     <= 1'b0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            txf_rd        <= 1'b0;
            rxf_wr        <= 1'b0;
            rxf_din       <= 8'd0;
            spi_start     <= 1'b0;
            spi_continued <= 1'b0;
            spi_txData    <= 8'hFF;
`ifdef SPI_SEQ_WIP_POLL_EN
            poll_r        <= 16'd0;
`endif
        end else begin
            state_r       <= state_s;
            phase_r       <= phase_s;
            cnt_r         <= cnt_s;
            idx_r         <= idx_s;
            gap_r         <= gap_s;
            dir_r         <= dir_s;
            addr_r        <= addr_s;
            ready_q_r     <= spi_ready;
            cmd_ready     <= cmd_ready_s;
            busy          <= busy_s;
            done          <= done_s;
            err           <= err_s;
            txf_rd        <= txf_rd_s;
            rxf_wr        <= rxf_wr_s;
            rxf_din       <= rxf_din_s;
            spi_start     <= spi_start_s;
            spi_continued <= spi_continued_s;
            spi_txData    <= spi_txData_s;
`ifdef SPI_SEQ_WIP_POLL_EN
            poll_r        <= poll_s;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s         = state_r;
        phase_s         = phase_r;
        cnt_s           = cnt_r;
        idx_s           = idx_r;
        gap_s           = gap_r;
        dir_s           = dir_r;
        addr_s          = addr_r;
        done_s          = 1'b0;
        err_s           = 1'b0;
        txf_rd_s        = 1'b0;
        rxf_wr_s        = 1'b0;
        rxf_din_s       = rxf_din;
        spi_start_s     = 1'b0;
        spi_continued_s = spi_continued;
        spi_txData_s    = spi_txData;
`ifdef SPI_SEQ_WIP_POLL_EN
        poll_s          = poll_r;
`endif
        case (state_r)
            S_IDLE, S_DONE: begin
                if (cmd_valid && cmd_ready) begin
                    dir_s  = cmd_dir;
                    addr_s = cmd_addr;
                    cnt_s  = cmd_len;
                    idx_s  = 2'd0;
                    if (cmd_len == 4'd0) begin
                        state_s = S_DONE;
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                    end else if (cmd_dir) begin
                        state_s = S_WREN;
                        phase_s = PH_WREN;
                    end else begin
                        state_s = S_HDR;
                        phase_s = PH_HDR;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WREN: begin
                if (spi_ready) begin
                    spi_start_s     = 1'b1;
                    spi_txData_s    = 8'h06;
                    spi_continued_s = 1'b0;
                    state_s         = S_WAIT;
                end else begin
                    state_s = S_WREN;
                end
            end
            S_GAP: begin
                if (gap_r <= 8'd1) begin
`ifdef SPI_SEQ_WIP_POLL_EN
                    if (phase_r == PH_WREN) begin
                        state_s = S_HDR;
                        phase_s = PH_HDR;
                        idx_s   = 2'd0;
                    end else begin
                        state_s = S_POLL;
                    end
`else
                    state_s = S_HDR;
                    phase_s = PH_HDR;
                    idx_s   = 2'd0;
`endif
                end else begin
                    gap_s = gap_r - 8'd1;
                end
            end
            S_HDR: begin
                if (spi_ready) begin
                    spi_start_s     = 1'b1;
                    spi_continued_s = 1'b1;
                    case (idx_r)
                        2'd0:    spi_txData_s = dir_r ? 8'h02 : 8'h03;
                        2'd1:    spi_txData_s = addr_r[15:8];
                        default: spi_txData_s = addr_r[7:0];
                    endcase
                    state_s = S_WAIT;
                end else begin
                    state_s = S_HDR;
                end
            end
            S_FETCH: begin
                // An empty FIFO simply parks here; CS stays low since the last byte had continued set.
                if (!txf_empty) begin
                    txf_rd_s = 1'b1;
                    state_s  = S_LOAD;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_LOAD: begin
                state_s = S_SEND;
            end
            S_SEND: begin
                if (spi_ready && (dir_r || !rxf_full)) begin
                    spi_start_s     = 1'b1;
                    spi_txData_s    = dir_r ? txf_dout : 8'hFF;
                    spi_continued_s = (cnt_r != 4'd1);
                    state_s         = S_WAIT;
                end else begin
                    state_s = S_SEND;
                end
            end
            S_WAIT: begin
                if (ready_rise_s) begin
                    case (phase_r)
                        PH_WREN: begin
                            state_s = S_GAP;
                            gap_s   = GAP_LOAD;
                        end
                        PH_HDR: begin
                            if (idx_r == 2'd2) begin
                                phase_s = PH_DATA;
                                state_s = dir_r ? S_FETCH : S_SEND;
                            end else begin
                                idx_s   = idx_r + 2'd1;
                                state_s = S_HDR;
                            end
                        end
                        PH_DATA: begin
                            if (!dir_r) begin
                                rxf_wr_s  = 1'b1;
                                rxf_din_s = spi_rxData;
                                state_s   = S_PUSH;
                            end else if (cnt_r == 4'd1) begin
`ifdef SPI_SEQ_WIP_POLL_EN
                                state_s = S_GAP;
                                gap_s   = GAP_LOAD;
                                phase_s = PH_RDSR_CMD;
                                poll_s  = 16'd0;
`else
                                state_s = S_DONE;
                                done_s  = 1'b1;
`endif
                            end else begin
                                cnt_s   = cnt_r - 4'd1;
                                state_s = S_FETCH;
                            end
                        end
`ifdef SPI_SEQ_WIP_POLL_EN
                        PH_RDSR_CMD: begin
                            phase_s = PH_RDSR_STAT;
                            state_s = S_POLL;
                        end
                        PH_RDSR_STAT: begin
                            if (!spi_rxData[0]) begin
                                state_s = S_DONE;
                                done_s  = 1'b1;
                            end else if (poll_r == (POLL_MAX - 16'd1)) begin
                                state_s = S_DONE;
                                done_s  = 1'b1;
                                err_s   = 1'b1;
                            end else begin
                                poll_s  = poll_r + 16'd1;
                                phase_s = PH_RDSR_CMD;
                                state_s = S_GAP;
                                gap_s   = GAP_LOAD;
                            end
                        end
`endif
                        default: begin
                            state_s = S_DONE;
                            done_s  = 1'b1;
                            err_s   = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_PUSH: begin
                if (cnt_r == 4'd1) begin
                    state_s = S_DONE;
                    done_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                    state_s = S_SEND;
                end
            end
`ifdef SPI_SEQ_WIP_POLL_EN
            S_POLL: begin
                if (spi_ready) begin
                    spi_start_s = 1'b1;
                    if (phase_r == PH_RDSR_CMD) begin
                        spi_txData_s    = 8'h05;
                        spi_continued_s = 1'b1;
                    end else begin
                        spi_txData_s    = 8'hFF;
                        spi_continued_s = 1'b0;
                    end
                    state_s = S_WAIT;
                end else begin
                    state_s = S_POLL;
                end
            end
`endif
            default: begin
                state_s = S_IDLE;
            end
        endcase
        busy_s      = (state_s != S_IDLE) && (state_s != S_DONE);
        cmd_ready_s = !busy_s;
    end

endmodule

// File: tb/tb_spi_eeprom_sequencer.sv
// Directed bench for spi_eeprom_sequencer with a byte-sender model and TX/RX FIFO models.
module tb_spi_eeprom_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_dir;
    logic [15:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        busy, done, err, txf_rd, txf_empty, rxf_wr, rxf_full;
    logic [7:0]  txf_dout = 8'h00;
    logic [7:0]  rxf_din;
    logic        spi_start, spi_continued;
    logic [7:0]  spi_txData;
    logic [7:0]  spi_rxData = 8'h00;
    logic        spi_ready = 1'b1;

    spi_eeprom_sequencer dut (
        .bus2ip_clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .busy(busy), .done(done), .err(err),
        .txf_rd(txf_rd), .txf_dout(txf_dout), .txf_empty(txf_empty),
        .rxf_wr(rxf_wr), .rxf_din(rxf_din), .rxf_full(rxf_full),
        .spi_start(spi_start), .spi_continued(spi_continued), .spi_txData(spi_txData),
        .spi_rxData(spi_rxData), .spi_ready(spi_ready)
    );

    always #5 clk = ~clk;

    // FIFO contents are written by the stimulus process, consumed by the model process.
    logic [7:0] tx_mem [256];
    logic [7:0] resp_mem [256];
    logic [7:0] tx_wr = 8'd0, tx_rd = 8'd0, resp_wr = 8'd0, resp_rd = 8'd0;
    assign txf_empty = (tx_rd == tx_wr);

    logic [7:0] tx_log [256];
    logic       cont_log [256];
    logic [7:0] rx_log [256];
    int start_cyc [256];
    int rise_cyc [256];
    int rd_cyc [256];
    int wr_cyc [256];
    int n_tx = 0, n_rise = 0, n_rd = 0, n_wr = 0;
    int cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, proto_err = 0, busy_cnt = 0;
    logic last_err = 1'b0, ready_prev = 1'b1, start_prev = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int b_tx, b_rise, b_rd, b_wr, old_done;

    // Sender model, FIFO models and event recorder.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        ready_prev <= spi_ready;
        start_prev <= spi_start;
        if (rst) begin
            spi_ready <= 1'b1;
            busy_cnt  <= 0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cyc <= cyc;
            proto_err <= proto_err + ((spi_start && (!spi_ready || start_prev)) ? 1 : 0)
                                   + ((txf_rd && txf_empty) ? 1 : 0)
                                   + ((rxf_wr && rxf_full) ? 1 : 0);
            if (spi_start) begin
                tx_log[n_tx[7:0]]    <= spi_txData;
                cont_log[n_tx[7:0]]  <= spi_continued;
                start_cyc[n_tx[7:0]] <= cyc;
                n_tx      <= n_tx + 1;
                spi_ready <= 1'b0;
                busy_cnt  <= 3;
            end else if (!spi_ready) begin
                if (busy_cnt == 1) begin
                    spi_ready  <= 1'b1;
                    spi_rxData <= (resp_rd != resp_wr) ? resp_mem[resp_rd] : 8'h00;
                    if (resp_rd != resp_wr) resp_rd <= resp_rd + 8'd1;
                end
                busy_cnt <= busy_cnt - 1;
            end
            if (spi_ready && !ready_prev) begin
                rise_cyc[n_rise[7:0]] <= cyc;
                n_rise <= n_rise + 1;
            end
            if (txf_rd) begin
                if (!txf_empty) begin
                    txf_dout <= tx_mem[tx_rd];
                    tx_rd    <= tx_rd + 8'd1;
                end
                rd_cyc[n_rd[7:0]] <= cyc;
                n_rd <= n_rd + 1;
            end
            if (rxf_wr) begin
                rx_log[n_wr[7:0]] <= rxf_din;
                wr_cyc[n_wr[7:0]] <= cyc;
                n_wr <= n_wr + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                last_err <= err;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] out_vec();
        return {cmd_ready, busy, done, err, txf_rd, rxf_wr, spi_start, spi_continued,
                spi_txData, rxf_din};
    endfunction

    task automatic push_tx(input logic [7:0] b);
        tx_mem[tx_wr] = b;
        tx_wr = tx_wr + 8'd1;
    endtask

    task automatic push_resp(input logic [7:0] b);
        resp_mem[resp_wr] = b;
        resp_wr = resp_wr + 8'd1;
    endtask

    task automatic snap();
        b_tx = n_tx; b_rise = n_rise; b_rd = n_rd; b_wr = n_wr; old_done = done_cnt;
    endtask

    task automatic run_cmd(input logic d, input logic [15:0] a, input logic [3:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = d; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt == old_done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, done_cnt - old_done, 1);
    endtask

    task automatic wait_starts(input int n, input string tag);
        int k = 0;
        while ((n_tx - b_tx) < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, n_tx - b_tx, n);
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp [6], input logic [5:0] exp_cont);
        logic [5:0] cv = 6'd0;
        check_val({tag, "_count"}, n_tx - b_tx, 6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("%s_byte%0d", tag, i), tx_log[(b_tx + i) % 256], exp[i]);
            cv = {cv[4:0], cont_log[(b_tx + i) % 256]};
        end
        check_val({tag, "_cont"}, cv, exp_cont);
    endtask

    initial begin
        logic [7:0] exp_w [6];
        logic [7:0] exp_r [6];
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = 16'd0; cmd_len = 4'd0;
        rxf_full = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", out_vec(), 24'h80FF00);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_outputs", out_vec(), 24'h80FF00);

        // Write 0x0120, two bytes.
        push_tx(8'hA5); push_tx(8'h3C);
        snap();
        run_cmd(1'b1, 16'h0120, 4'd2);
        wait_done("wr_done");
        check_val("wr_err", last_err, 0);
        exp_w = '{8'h06, 8'h02, 8'h01, 8'h20, 8'hA5, 8'h3C};
        check_bytes("wr", exp_w, 6'b011110);
        check_val("wr_latency", start_cyc[b_tx % 256] - acc_cyc, 2);
        check_val("wr_gap", start_cyc[(b_tx + 1) % 256] - rise_cyc[b_rise % 256], 4);
        check_val("wr_txpath", start_cyc[(b_tx + 4) % 256] - rd_cyc[b_rd % 256], 2);
        check_val("wr_done_time", done_cyc - rise_cyc[(b_rise + 5) % 256], 1);
        check_val("wr_no_rxwr", n_wr - b_wr, 0);

        // Read 0x7FFF, three bytes.
        push_resp(8'hEE); push_resp(8'hEE); push_resp(8'hEE);
        push_resp(8'h11); push_resp(8'h22); push_resp(8'h33);
        snap();
        run_cmd(1'b0, 16'h7FFF, 4'd3);
        wait_done("rd_done");
        check_val("rd_err", last_err, 0);
        exp_r = '{8'h03, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_bytes("rd", exp_r, 6'b111110);
        check_val("rd_latency", start_cyc[b_tx % 256] - acc_cyc, 2);
        check_val("rd_wr_count", n_wr - b_wr, 3);
        check_val("rd_data0", rx_log[b_wr % 256], 8'h11);
        check_val("rd_data1", rx_log[(b_wr + 1) % 256], 8'h22);
        check_val("rd_data2", rx_log[(b_wr + 2) % 256], 8'h33);
        check_val("rd_wr_time", wr_cyc[b_wr % 256] - rise_cyc[(b_rise + 3) % 256], 1);
        check_val("rd_done_time", done_cyc - wr_cyc[(b_wr + 2) % 256], 1);

        // Write with TX FIFO empty after the header.
        snap();
        run_cmd(1'b1, 16'h0010, 4'd1);
        wait_starts(4, "stall_hdr");
        repeat (50) @(negedge clk);
        check_val("stall_no_start", n_tx - b_tx, 4);
        check_val("stall_cs_low", cont_log[(b_tx + 3) % 256], 1);
        check_val("stall_busy", busy, 1);
        push_tx(8'h5A);
        wait_done("stall_done");
        check_val("stall_total", n_tx - b_tx, 5);
        check_val("stall_byte", tx_log[(b_tx + 4) % 256], 8'h5A);
        check_val("stall_last_cont", cont_log[(b_tx + 4) % 256], 0);
        check_val("stall_err", last_err, 0);

        // Read with RX FIFO full.
        rxf_full = 1'b1;
        push_resp(8'hEE); push_resp(8'hEE); push_resp(8'hEE);
        push_resp(8'hAB); push_resp(8'hCD);
        snap();
        run_cmd(1'b0, 16'h0200, 4'd2);
        wait_starts(3, "full_hdr");
        repeat (30) @(negedge clk);
        check_val("full_hold", n_tx - b_tx, 3);
        check_val("full_no_wr", n_wr - b_wr, 0);
        rxf_full = 1'b0;
        wait_done("full_done");
        check_val("full_total", n_tx - b_tx, 5);
        check_val("full_wr_count", n_wr - b_wr, 2);
        check_val("full_data0", rx_log[b_wr % 256], 8'hAB);
        check_val("full_data1", rx_log[(b_wr + 1) % 256], 8'hCD);

        // Zero-length command.
        snap();
        run_cmd(1'b1, 16'h0000, 4'd0);
        wait_done("len0_done");
        check_val("len0_time", done_cyc - acc_cyc, 1);
        check_val("len0_err", last_err, 1);
        repeat (5) @(negedge clk);
        check_val("len0_no_start", n_tx - b_tx, 0);

`ifdef SPI_SEQ_WIP_POLL_EN
        // Write followed by RDSR polling: WIP=1 three times then 0.
        push_tx(8'h77);
        for (int i = 0; i < 5; i++) push_resp(8'h00);
        for (int i = 0; i < 3; i++) begin
            push_resp(8'h00); push_resp(8'h01);
        end
        push_resp(8'h00); push_resp(8'h00);
        snap();
        run_cmd(1'b1, 16'h0040, 4'd1);
        wait_done("poll_done");
        check_val("poll_err", last_err, 0);
        check_val("poll_total", n_tx - b_tx, 13);
        check_val("poll_first", tx_log[(b_tx + 5) % 256], 8'h05);
        check_val("poll_last", tx_log[(b_tx + 12) % 256], 8'hFF);
        check_val("poll_gap", start_cyc[(b_tx + 5) % 256] - rise_cyc[(b_rise + 4) % 256], 4);
`endif

        // Reset in the middle of a write.
        push_tx(8'h11); push_tx(8'h22);
        snap();
        run_cmd(1'b1, 16'h0300, 4'd2);
        wait_starts(2, "rst_progress");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_async_outputs", out_vec(), 24'h80FF00);
        repeat (2) @(negedge clk);
        tx_wr = tx_rd;
        resp_wr = resp_rd;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rst_no_done", done_cnt - old_done, 0);
        check_val("rst_idle_outputs", out_vec(), 24'h80FF00);

        check_val("protocol_violations", proto_err, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
